// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM link: decoder states, nominal timing
// constants shared with the generator, and position code values.
package servo_pkg;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

  localparam int unsigned SERVO_PERIOD_CYC  = 1_000_000;
  localparam int unsigned SERVO_W0_CYC      = 50_000;
  localparam int unsigned SERVO_W1_CYC      = 150_000;
  localparam int unsigned SERVO_W2_CYC      = 250_000;
  localparam int unsigned SERVO_TOL_CYC     = 5_000;
  localparam int unsigned SERVO_TIMEOUT_CYC = 2_000_000;
  localparam int unsigned SERVO_CNT_W       = 21;

  localparam logic [1:0] POS_0 = 2'b00;
  localparam logic [1:0] POS_1 = 2'b01;
  localparam logic [1:0] POS_2 = 2'b10;

  // True when the three tolerance windows are strictly separated.
  function automatic logic windows_disjoint(input int unsigned w0, input int unsigned w1,
                                            input int unsigned w2, input int unsigned tol);
    return (w0 >= tol) && (w0 + tol < w1 - tol) && (w1 + tol < w2 - tol);
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_sync.sv
// 2-FF synchronizer with registered rise/fall pulses; level is time-aligned
// with the pulses so downstream logic sees a consistent view of the pin.
module servo_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s;
  logic s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      s    <= RST_VAL;
      s_d  <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      s    <= meta;
      s_d  <= s;
      rise <= s & ~s_d;
      fall <= ~s & s_d;
    end
  end

  assign level = s_d;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures pulse high time, decodes it to a 2-bit
// position code, and flags out-of-range pulses, stuck-high input and signal loss.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = SERVO_PERIOD_CYC,
  parameter int unsigned W0_CYC      = SERVO_W0_CYC,
  parameter int unsigned W1_CYC      = SERVO_W1_CYC,
  parameter int unsigned W2_CYC      = SERVO_W2_CYC,
  parameter int unsigned TOL_CYC     = SERVO_TOL_CYC,
  parameter int unsigned TIMEOUT_CYC = SERVO_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = SERVO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             servo_i,
  output logic [1:0]       pos_o,
  output logic [CNT_W-1:0] width_o,
  output logic             pos_valid_o,
  output logic             range_err_o,
  output logic             stuck_o,
  output logic             lost_o
);

  if (!windows_disjoint(W0_CYC, W1_CYC, W2_CYC, TOL_CYC)) begin : g_bad_windows
    $error("servo_pwm_decoder: decode windows overlap");
  end
  if (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("servo_pwm_decoder: CNT_W too narrow for TIMEOUT_CYC");
  end

  localparam logic [CNT_W-1:0] LO0         = CNT_W'(W0_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] HI0         = CNT_W'(W0_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0] LO1         = CNT_W'(W1_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] HI1         = CNT_W'(W1_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0] LO2         = CNT_W'(W2_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] HI2         = CNT_W'(W2_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0] PERIOD_MAX  = CNT_W'(PERIOD_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYC);

  logic level;
  logic rise;
  logic fall;

  // Pipeline resets high so a pin already high at reset release looks like
  // a pulse in progress and is skipped by the arming state.
  servo_sync_edge #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (servo_i),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  state_e           state;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic             hit0;
  logic             hit1;
  logic             hit2;

  always_comb begin
    hit0 = (width_cnt >= LO0) && (width_cnt <= HI0);
    hit1 = (width_cnt >= LO1) && (width_cnt <= HI1);
    hit2 = (width_cnt >= LO2) && (width_cnt <= HI2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ARM;
      width_cnt   <= '0;
      per_cnt     <= '0;
      pos_o       <= POS_0;
      width_o     <= '0;
      pos_valid_o <= 1'b0;
      range_err_o <= 1'b0;
      stuck_o     <= 1'b0;
      lost_o      <= 1'b1;
    end else begin
      pos_valid_o <= 1'b0;
      range_err_o <= 1'b0;
      stuck_o     <= 1'b0;

      // A rising edge beats a coincident timeout; a good decode clears lost_o
      // below because its later assignment takes precedence.
      if (state != S_ARM) begin
        if (state == S_LOW && rise) begin
          per_cnt <= '0;
        end else if (per_cnt != TIMEOUT_MAX) begin
          per_cnt <= per_cnt + 1'b1;
          if (per_cnt == TIMEOUT_MAX - 1'b1) lost_o <= 1'b1;
        end
      end

      case (state)
        S_ARM: begin
          if (!level) state <= S_LOW;
        end
        S_LOW: begin
          if (rise) begin
            width_cnt <= CNT_W'(1);
            state     <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state   <= S_LOW;
            width_o <= width_cnt;
            if (hit0 || hit1 || hit2) begin
              pos_o       <= hit0 ? POS_0 : (hit1 ? POS_1 : POS_2);
              pos_valid_o <= 1'b1;
              lost_o      <= 1'b0;
            end else begin
              range_err_o <= 1'b1;
            end
          end else if (width_cnt == PERIOD_MAX - 1'b1) begin
            stuck_o   <= 1'b1;
            width_cnt <= PERIOD_MAX;
            state     <= S_ARM;
          end else begin
            width_cnt <= width_cnt + 1'b1;
          end
        end
        default: state <= S_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with scaled timing: a pulse-run model of the
// delayed input stream is compared every cycle, plus literal event checks.
module tb_servo_pwm_decoder;

  localparam int unsigned P   = 1000;
  localparam int unsigned W0  = 50;
  localparam int unsigned W1  = 150;
  localparam int unsigned W2  = 250;
  localparam int unsigned TOL = 5;
  localparam int unsigned T   = 2000;
  localparam int unsigned CW  = 12;

  localparam int EV_VALID = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_STUCK = 3;
  localparam int EV_LOST  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          servo_i;
  logic [1:0]    pos_o;
  logic [CW-1:0] width_o;
  logic          pos_valid_o;
  logic          range_err_o;
  logic          stuck_o;
  logic          lost_o;

  servo_pwm_decoder #(
    .PERIOD_CYC (P),
    .W0_CYC     (W0),
    .W1_CYC     (W1),
    .W2_CYC     (W2),
    .TOL_CYC    (TOL),
    .TIMEOUT_CYC(T),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .servo_i    (servo_i),
    .pos_o      (pos_o),
    .width_o    (width_o),
    .pos_valid_o(pos_valid_o),
    .range_err_o(range_err_o),
    .stuck_o    (stuck_o),
    .lost_o     (lost_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int pos;
    int width;
    int edge_k;
  } ev_t;

  ev_t evq[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  // Model state: input history seen through the fixed 3-edge latency.
  logic hist[5];
  int   m_pos, m_width, m_valid, m_err, m_stuck, m_lost;
  bit   waiting_low;
  bit   in_run;
  int   run_len;
  int   since_edge;
  logic prev_lost = 1'b1;
  logic rst_s = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic x);
    logic cur, prev, rose, fell, counted;
    int   nom[3];
    int   d;
    bit   hit;
    cyc++;
    rst_s   = r;
    m_valid = 0;
    m_err   = 0;
    m_stuck = 0;
    if (r) begin
      for (int i = 0; i < 5; i++) hist[i] = 1'b1;
      m_pos = 0; m_width = 0; m_lost = 1;
      waiting_low = 1; in_run = 0; run_len = 0; since_edge = 0;
      return;
    end
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    cur  = hist[3];
    prev = hist[4];
    rose = cur && !prev;
    fell = !cur && prev;
    counted = !waiting_low;
    if (waiting_low && !cur) waiting_low = 0;
    if (counted) begin
      if (rose) since_edge = 0;
      else if (since_edge < int'(T)) begin
        since_edge++;
        if (since_edge == int'(T)) m_lost = 1;
      end
    end
    if (rose && counted) begin
      in_run = 1;
      run_len = 1;
    end else if (in_run && cur) begin
      run_len++;
    end
    if (in_run && cur && run_len == int'(P)) begin
      m_stuck = 1; in_run = 0; waiting_low = 1;
    end else if (in_run && fell) begin
      in_run  = 0;
      m_width = run_len;
      nom = '{int'(W0), int'(W1), int'(W2)};
      hit = 0;
      for (int c = 0; c < 3; c++) begin
        d = run_len - nom[c];
        if (d < 0) d = -d;
        if (!hit && d <= int'(TOL)) begin
          m_pos = c;
          hit = 1;
        end
      end
      if (hit) begin
        m_valid = 1;
        m_lost  = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare_cycle();
    chk("pos_o", int'(pos_o), m_pos);
    chk("width_o", int'(width_o), m_width);
    chk("pos_valid_o", int'(pos_valid_o), m_valid);
    chk("range_err_o", int'(range_err_o), m_err);
    chk("stuck_o", int'(stuck_o), m_stuck);
    chk("lost_o", int'(lost_o), m_lost);
    if (pos_valid_o) evq.push_back('{EV_VALID, int'(pos_o), int'(width_o), cyc});
    if (range_err_o) evq.push_back('{EV_ERR, int'(pos_o), int'(width_o), cyc});
    if (stuck_o)     evq.push_back('{EV_STUCK, int'(pos_o), int'(width_o), cyc});
    if (!rst_s && lost_o && !prev_lost)
      evq.push_back('{EV_LOST, int'(pos_o), int'(width_o), cyc});
    prev_lost = lost_o;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step(rst, servo_i);
    compare_cycle();
  endtask

  task automatic drive(input logic v, input int n);
    servo_i = v;
    repeat (n) tick();
  endtask

  task automatic pulse(input int hi, input int lo, output int rise_e, output int fall_e);
    rise_e = cyc + 1;
    drive(1'b1, hi);
    fall_e = cyc + 1;
    drive(1'b0, lo);
  endtask

  task automatic expect_ev(input string nm, input int kind, input int pos, input int width,
                           input int edge_k);
    ev_t e;
    if (evq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no event, expected kind %0d at edge %0d", nm, kind, edge_k);
    end else begin
      e = evq.pop_front();
      chk({nm, ".kind"}, e.kind, kind);
      chk({nm, ".pos"}, e.pos, pos);
      chk({nm, ".width"}, e.width, width);
      chk({nm, ".edge"}, e.edge_k, edge_k);
    end
  endtask

  task automatic expect_none(input string nm);
    chk(nm, evq.size(), 0);
    evq.delete();
  endtask

  int r, f, r1, f1;

  initial begin
    rst = 1'b1;
    servo_i = 1'b0;
    repeat (4) tick();
    rst = 1'b0;

    drive(1'b0, 3000);
    chk("idle.lost_o", int'(lost_o), 1);
    chk("idle.pos_o", int'(pos_o), 0);
    expect_none("idle.events");

    pulse(50, 950, r, f);
    expect_ev("code0", EV_VALID, 0, 50, f + 3);
    chk("code0.lost_o", int'(lost_o), 0);
    pulse(150, 850, r, f);
    expect_ev("code1", EV_VALID, 1, 150, f + 3);
    pulse(250, 750, r, f);
    expect_ev("code2", EV_VALID, 2, 250, f + 3);

    pulse(155, 845, r, f);
    expect_ev("w155", EV_VALID, 1, 155, f + 3);
    pulse(156, 844, r, f);
    expect_ev("w156", EV_ERR, 1, 156, f + 3);
    chk("w156.pos_o", int'(pos_o), 1);
    pulse(45, 955, r, f);
    expect_ev("w45", EV_VALID, 0, 45, f + 3);
    pulse(44, 956, r, f);
    expect_ev("w44", EV_ERR, 0, 44, f + 3);

    pulse(150, 850, r, f);
    expect_ev("pre_stuck", EV_VALID, 1, 150, f + 3);
    pulse(1200, 500, r, f);
    expect_ev("stuck", EV_STUCK, 1, 150, r + int'(P) + 2);
    expect_none("stuck.extra");
    pulse(150, 850, r, f);
    expect_ev("post_stuck", EV_VALID, 1, 150, f + 3);

    pulse(150, int'(T) + 100, r, f);
    expect_ev("pre_lost", EV_VALID, 1, 150, f + 3);
    expect_ev("lost", EV_LOST, 1, 150, r + 3 + int'(T));

    pulse(150, int'(T) - 150, r, f);
    pulse(150, 850, r1, f1);
    expect_ev("race.first", EV_VALID, 1, 150, f + 3);
    expect_ev("race.second", EV_VALID, 1, 150, f1 + 3);
    expect_none("race.no_lost");
    chk("race.lost_o", int'(lost_o), 0);

    drive(1'b1, 20);
    rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 128);
    drive(1'b0, 850);
    expect_none("rst_mid.events");
    chk("rst_mid.pos_o", int'(pos_o), 0);
    chk("rst_mid.lost_o", int'(lost_o), 1);
    pulse(150, 850, r, f);
    expect_ev("rst_mid.next", EV_VALID, 1, 150, f + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
